// File: rtl/spram_banked_pkg.sv
// Shared state types and width helpers for the banked single-port RAM.
package spram_banked_pkg;

  typedef enum logic {S_CLEAR, S_RUN} top_state_t;

  typedef enum logic [1:0] {B_ACTIVE, B_SLEEP, B_WAKING} bank_state_t;

  localparam int BYTE_W = 8;

  // Width of a field able to index n items; never narrower than one bit.
  function automatic int bitsFor(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One BANK_DEPTH x DATA_WIDTH bank: byte-masked write, registered read.
// A vendor macro wrapper would replace the behavioural array here.
module spram_bank
  import spram_banked_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int BANK_DEPTH = 16384,
  localparam int ROW_BITS   = bitsFor(BANK_DEPTH),
  localparam int MASK_WIDTH = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  i_en,
  input  logic                  i_sleep,
  input  logic                  i_we,
  input  logic [MASK_WIDTH-1:0] i_mask,
  input  logic [ROW_BITS-1:0]   i_row,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_go;

  assign w_go    = i_en && !i_sleep;
  assign o_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (w_go && i_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (i_mask[i]) r_mem[i_row][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // The read register only moves on a read, so the last read word is held.
  always_ff @(posedge clk) begin
    if (!reset_n_i)          r_rdata <= '0;
    else if (w_go && !i_we)  r_rdata <= r_mem[i_row];
  end

endmodule

// File: rtl/spram_banked.sv
// Banked single-port RAM with post-reset zero-fill, ready handshake and
// per-bank idle sleep with a fixed wake-up stall.
module spram_banked
  import spram_banked_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int BANK_DEPTH     = 16384,
  parameter  int NUM_BANKS      = 2,
  parameter  int IDLE_SLEEP     = 64,
  parameter  int WAKE_CYCLES    = 2,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH     = $clog2(BANK_DEPTH * NUM_BANKS),
  localparam int MASK_WIDTH     = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  sel_i,
  output logic                  ready_o,
  input  logic                  wr_en_i,
  input  logic [MASK_WIDTH-1:0] wr_mask_i,
  input  logic [ADDR_WIDTH-1:0] address_in_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic [NUM_BANKS-1:0]  sleep_o
);

  localparam int ROW_BITS  = bitsFor(BANK_DEPTH);
  localparam int BANK_BITS = bitsFor(NUM_BANKS);
  localparam int ICNT_W    = bitsFor(IDLE_SLEEP + 1);
  localparam int WCNT_W    = bitsFor(WAKE_CYCLES);
  localparam logic [ICNT_W-1:0] IDLE_MAX  = ICNT_W'(IDLE_SLEEP);
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);

  top_state_t            r_state, w_stateNext;
  logic [ROW_BITS-1:0]   r_clrRow;
  logic [BANK_BITS-1:0]  w_bank, r_rdBank;
  logic [ROW_BITS-1:0]   w_row;
  logic                  w_run, w_clearing, w_accept, r_rdValid;
  logic                  w_bankWe;
  logic [MASK_WIDTH-1:0] w_bankMask;
  logic [ROW_BITS-1:0]   w_bankRow;
  logic [DATA_WIDTH-1:0] w_bankWdata;
  logic [DATA_WIDTH-1:0] w_rdata [NUM_BANKS];
  bank_state_t           w_bankState [NUM_BANKS];

  generate
    if (NUM_BANKS > 1) begin : g_multi
      assign w_bank = address_in_i[ADDR_WIDTH-1:ROW_BITS];
    end else begin : g_single
      assign w_bank = '0;
    end
  endgenerate
  assign w_row = address_in_i[ROW_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_state  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      r_clrRow <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_CLEAR) r_clrRow <= r_clrRow + 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (r_state == S_CLEAR && r_clrRow == ROW_BITS'(BANK_DEPTH - 1)) w_stateNext = S_RUN;
  end

  assign w_run      = reset_n_i && (r_state == S_RUN);
  assign w_clearing = reset_n_i && (r_state == S_CLEAR);
  assign busy_o     = (r_state == S_CLEAR);
  assign ready_o    = w_run && (w_bankState[w_bank] == B_ACTIVE);
  assign w_accept   = sel_i && ready_o;

  // Zero-fill drives every bank in parallel; otherwise the request fields pass through.
  assign w_bankWe    = w_clearing ? 1'b1 : wr_en_i;
  assign w_bankMask  = w_clearing ? '1   : wr_mask_i;
  assign w_bankRow   = w_clearing ? r_clrRow : w_row;
  assign w_bankWdata = w_clearing ? '0   : data_in_i;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_state_t         r_bst, w_bstNext;
    logic [ICNT_W-1:0]   r_idle, w_idleNext;
    logic [WCNT_W-1:0]   r_wake, w_wakeNext;
    logic                w_hit, w_acc;

    assign w_hit = w_run && sel_i && (w_bank == BANK_BITS'(b));
    assign w_acc = w_hit && (r_bst == B_ACTIVE);

    always_ff @(posedge clk) begin
      if (!reset_n_i) begin
        r_bst  <= B_ACTIVE;
        r_idle <= '0;
        r_wake <= '0;
      end else begin
        r_bst  <= w_bstNext;
        r_idle <= w_idleNext;
        r_wake <= w_wakeNext;
      end
    end

    // Idle count saturates at IDLE_MAX; the bank sleeps on the cycle it gets there.
    always_comb begin
      w_bstNext  = r_bst;
      w_idleNext = r_idle;
      w_wakeNext = r_wake;
      if (w_run) begin
        case (r_bst)
          B_ACTIVE: begin
            if (w_acc)                  w_idleNext = '0;
            else if (r_idle != IDLE_MAX) w_idleNext = r_idle + 1'b1;
            if (IDLE_SLEEP != 0 && !w_acc && w_idleNext == IDLE_MAX) w_bstNext = B_SLEEP;
          end
          B_SLEEP: begin
            if (w_hit) begin
              w_bstNext  = B_WAKING;
              w_wakeNext = '0;
              w_idleNext = '0;
            end
          end
          B_WAKING: begin
            if (r_wake == WAKE_LAST) w_bstNext  = B_ACTIVE;
            else                     w_wakeNext = r_wake + 1'b1;
          end
          default: w_bstNext = B_ACTIVE;
        endcase
      end
    end

    assign w_bankState[b] = r_bst;
    assign sleep_o[b]     = (r_bst == B_SLEEP);

    spram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .BANK_DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .i_en      (w_clearing || w_acc),
      .i_sleep   (r_bst == B_SLEEP),
      .i_we      (w_bankWe),
      .i_mask    (w_bankMask),
      .i_row     (w_bankRow),
      .i_wdata   (w_bankWdata),
      .o_rdata   (w_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_rdValid <= 1'b0;
      r_rdBank  <= '0;
    end else begin
      r_rdValid <= w_accept && !wr_en_i;
      if (w_accept && !wr_en_i) r_rdBank <= w_bank;
    end
  end

  assign data_valid_o = r_rdValid;
  assign data_out_o   = w_rdata[r_rdBank];

endmodule

// File: tb/tb_spram_banked.sv
// Directed bench for spram_banked: zero-fill, masked writes, back-to-back
// access, idle sleep with wake stall, and reset during zero-fill.
module tb_spram_banked;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        sel_i;
  logic        ready_o;
  logic        wr_en_i;
  logic [3:0]  wr_mask_i;
  logic [5:0]  address_in_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        data_valid_o;
  logic        busy_o;
  logic [3:0]  sleep_o;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [9];

  spram_banked #(
    .DATA_WIDTH     (32),
    .BANK_DEPTH     (16),
    .NUM_BANKS      (4),
    .IDLE_SLEEP     (8),
    .WAKE_CYCLES    (3),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .sel_i        (sel_i),
    .ready_o      (ready_o),
    .wr_en_i      (wr_en_i),
    .wr_mask_i    (wr_mask_i),
    .address_in_i (address_in_i),
    .data_in_i    (data_in_i),
    .data_out_o   (data_out_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .sleep_o      (sleep_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Holds a request until accepted; returns one step after the accept edge.
  task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, output int stall);
    sel_i        = 1'b1;
    wr_en_i      = we;
    address_in_i = addr;
    data_in_i    = wdata;
    wr_mask_i    = mask;
    stall        = 0;
    #1;
    while (!ready_o && stall < 20) begin
      stall++;
      nextCycle();
      #1;
    end
    checkOutput("accept_ready", 32'(ready_o), 32'd1);
    nextCycle();
    sel_i = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    #1;
    while (busy_o && n < 100) begin
      n++;
      nextCycle();
      #1;
    end
  endtask

  initial begin
    int stall;
    int nBusy;

    vecs[0] = '{1'b1, 6'd5,  32'hAABBCCDD, 4'b1111, 32'h0};
    vecs[1] = '{1'b1, 6'd5,  32'h11223344, 4'b0101, 32'h0};
    vecs[2] = '{1'b0, 6'd5,  32'h0,        4'b0000, 32'hAA22CC44};
    vecs[3] = '{1'b1, 6'd5,  32'hFFFFFFFF, 4'b0000, 32'h0};
    vecs[4] = '{1'b0, 6'd5,  32'h0,        4'b0000, 32'hAA22CC44};
    vecs[5] = '{1'b1, 6'd63, 32'hDEADBEEF, 4'b1000, 32'h0};
    vecs[6] = '{1'b0, 6'd63, 32'h0,        4'b0000, 32'hDE000000};
    vecs[7] = '{1'b1, 6'd62, 32'h12345678, 4'b0011, 32'h0};
    vecs[8] = '{1'b0, 6'd62, 32'h0,        4'b0000, 32'h00005678};

    reset_n_i    = 1'b0;
    sel_i        = 1'b0;
    wr_en_i      = 1'b0;
    wr_mask_i    = 4'h0;
    address_in_i = 6'd0;
    data_in_i    = 32'h0;
    repeat (3) nextCycle();
    #1;
    checkOutput("rst_ready", 32'(ready_o), 32'd0);
    checkOutput("rst_valid", 32'(data_valid_o), 32'd0);
    checkOutput("rst_data", data_out_o, 32'h0);
    checkOutput("rst_sleep", 32'(sleep_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd1);

    nextCycle();
    reset_n_i = 1'b1;
    countBusy(nBusy);
    checkOutput("clear_cycles", 32'(nBusy), 32'd16);
    checkOutput("ready_after_clear", 32'(ready_o), 32'd1);

    $display("[TB] zero-fill readback of all 64 words");
    for (int a = 0; a < 64; a++) begin
      applyStimulus(1'b0, 6'(a), 32'h0, 4'h0, stall);
      checkOutput($sformatf("zero_valid_%0d", a), 32'(data_valid_o), 32'd1);
      checkOutput($sformatf("zero_data_%0d", a), data_out_o, 32'h0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, stall);
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d_valid", i), 32'(data_valid_o), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d_valid", i), 32'(data_valid_o), 32'd1);
        checkOutput($sformatf("vec%0d_data", i), data_out_o, vecs[i].expData);
      end
    end

    $display("[TB] back-to-back reads across banks");
    applyStimulus(1'b1, 6'd15, 32'h0F0F0F0F, 4'hF, stall);
    applyStimulus(1'b1, 6'd16, 32'h16161616, 4'hF, stall);
    applyStimulus(1'b0, 6'd15, 32'h0, 4'h0, stall);
    checkOutput("b2b_stall15", 32'(stall), 32'd0);
    checkOutput("b2b_valid15", 32'(data_valid_o), 32'd1);
    checkOutput("b2b_data15", data_out_o, 32'h0F0F0F0F);
    applyStimulus(1'b0, 6'd16, 32'h0, 4'h0, stall);
    checkOutput("b2b_stall16", 32'(stall), 32'd0);
    checkOutput("b2b_valid16", 32'(data_valid_o), 32'd1);
    checkOutput("b2b_data16", data_out_o, 32'h16161616);

    $display("[TB] read right after write");
    applyStimulus(1'b1, 6'd3, 32'h0BADF00D, 4'hF, stall);
    checkOutput("raw_wr_valid", 32'(data_valid_o), 32'd0);
    applyStimulus(1'b0, 6'd3, 32'h0, 4'h0, stall);
    checkOutput("raw_stall", 32'(stall), 32'd0);
    checkOutput("raw_valid", 32'(data_valid_o), 32'd1);
    checkOutput("raw_data", data_out_o, 32'h0BADF00D);
    nextCycle();
    checkOutput("raw_strobe_end", 32'(data_valid_o), 32'd0);
    checkOutput("raw_data_hold", data_out_o, 32'h0BADF00D);

    $display("[TB] bank 2 idle sleep and wake");
    applyStimulus(1'b1, 6'd40, 32'hCAFE0040, 4'hF, stall);
    repeat (7) nextCycle();
    checkOutput("sleep_idle7", 32'(sleep_o[2]), 32'd0);
    nextCycle();
    checkOutput("sleep_idle8", 32'(sleep_o[2]), 32'd1);
    applyStimulus(1'b0, 6'd40, 32'h0, 4'h0, stall);
    checkOutput("wake_stall", 32'(stall), 32'd4);
    checkOutput("wake_valid", 32'(data_valid_o), 32'd1);
    checkOutput("wake_data", data_out_o, 32'hCAFE0040);
    checkOutput("wake_sleep_clr", 32'(sleep_o[2]), 32'd0);

    $display("[TB] reset during zero-fill");
    reset_n_i = 1'b0;
    nextCycle();
    reset_n_i = 1'b1;
    repeat (7) nextCycle();
    #1;
    checkOutput("midclr_busy", 32'(busy_o), 32'd1);
    reset_n_i = 1'b0;
    nextCycle();
    nextCycle();
    #1;
    checkOutput("midclr_rst_busy", 32'(busy_o), 32'd1);
    checkOutput("midclr_rst_ready", 32'(ready_o), 32'd0);
    checkOutput("midclr_rst_data", data_out_o, 32'h0);
    nextCycle();
    reset_n_i = 1'b1;
    countBusy(nBusy);
    checkOutput("midclr_cycles", 32'(nBusy), 32'd16);
    applyStimulus(1'b0, 6'd5, 32'h0, 4'h0, stall);
    checkOutput("midclr_data5", data_out_o, 32'h0);
    applyStimulus(1'b0, 6'd40, 32'h0, 4'h0, stall);
    checkOutput("midclr_data40", data_out_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
